instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, memory read latency in cycles (legal 1..2).
REQ-002 SHALL have parameter NOP_INSTR, default 16'h0000, instruction word returned on a rejected fetch.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port RESET_L  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port REQ  input  1  fetch request, sampled only when BUSY=0.
REQ-006 SHALL have port PC  input  8  byte address of instruction, sampled with REQ.
REQ-007 SHALL have port MEM_ADDR  output  8  byte address to instruction memory.
REQ-008 SHALL have port MEM_RD  output  1  memory read strobe, one cycle per byte.
REQ-009 SHALL have port MEM_DATA  input  8  read byte, valid MEM_LAT cycles after the MEM_RD cycle.
REQ-010 SHALL have port Iout  output  16  assembled instruction, feeds the CPU Iin.
REQ-011 SHALL have port IVALID  output  1  one-cycle pulse, Iout newly valid.
REQ-012 SHALL have port BUSY  output  1  fetch in progress; REQ ignored while high.
REQ-013 SHALL have port ALIGN_ERR  output  1  one-cycle pulse, odd PC rejected.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE_LO, WAIT_LO, ISSUE_HI, WAIT_HI, DONE.
REQ-015 SHALL transition IDLE->ISSUE_LO on REQ=1, capturing PC into an internal address register.
REQ-016 SHALL drive MEM_RD=1, MEM_ADDR=captured PC in ISSUE_LO, then go to WAIT_LO.
REQ-017 SHALL stay in WAIT_LO for MEM_LAT cycles via a wait counter; capture MEM_DATA into Iout[7:0] at the last WAIT_LO edge; go to ISSUE_HI.
REQ-018 SHALL drive MEM_RD=1, MEM_ADDR=PC+1 (8-bit, 8'hFF wraps to 8'h00) in ISSUE_HI, then WAIT_HI behaves as WAIT_LO, capturing Iout[15:8]; go to DONE.
REQ-019 SHALL assert IVALID=1 for exactly the DONE cycle; latency REQ-sample cycle to IVALID cycle = 2*MEM_LAT+3 (5 at default).
REQ-020 SHALL hold Iout stable from DONE until the next fetch's low-byte capture; Iout updates byte-wise only.
REQ-021 SHALL drive BUSY=1 in ISSUE_LO..WAIT_HI, BUSY=0 in IDLE and DONE.
REQ-022 SHALL accept REQ in DONE (back-to-back): DONE->ISSUE_LO; else DONE->IDLE.
REQ-023 SHALL ignore REQ and PC while BUSY=1; no queuing.
REQ-024 SHALL keep MEM_RD=0 in all states other than ISSUE_LO/ISSUE_HI; MEM_ADDR holds last value otherwise.

Reset
REQ-025 SHALL on RESET_L=0, immediately and regardless of state: FSM=IDLE, Iout=16'h0000, IVALID=0, BUSY=0, MEM_RD=0, MEM_ADDR=8'h00, ALIGN_ERR=0, wait counter=0.
REQ-026 SHALL discard any in-flight fetch on reset mid-operation; a MEM_DATA return after reset release is ignored.
REQ-027 SHALL accept REQ on the first rising edge after RESET_L deasserts.

Configuration
REQ-028 SHALL, with IFETCH_ALIGN_CHK_EN defined, treat REQ with PC[0]=1 in IDLE/DONE as rejected: no memory access, next state DONE with Iout=NOP_INSTR, IVALID=1, ALIGN_ERR=1 for that cycle.
REQ-029 SHALL, without IFETCH_ALIGN_CHK_EN, fetch odd PC normally (bytes PC, PC+1) and tie ALIGN_ERR to 0.

Structure
REQ-030 SHALL place the FSM state encoding (3-bit), byte width (8), instruction width (16) in shared package ifetch_pkg.
REQ-031 SHALL be one module; no sub-module needed, wait counter is inline (1 bit sufficient for MEM_LAT<=2).

Verification
REQ-032 SHALL cover single fetch: MEM_LAT=1, PC=8'h10, mem[10]=8'h34, mem[11]=8'h12 -> IVALID 5 cycles after REQ, Iout=16'h1234, two MEM_RD pulses at 8'h10, 8'h11.
REQ-033 SHALL cover wrap: PC=8'hFE then PC=8'hFF (macro off) -> second fetch reads 8'hFF then 8'h00.
REQ-034 SHALL cover back-to-back: REQ held high, PC=8'h00,8'h02 -> IVALID pulses 5 cycles apart, REQ during BUSY ignored.
REQ-035 SHALL cover reset mid-fetch: RESET_L low during WAIT_HI -> Iout=16'h0000, BUSY=0, no IVALID pulse afterwards.
REQ-036 SHALL cover alignment (macro on): PC=8'h05 -> no MEM_RD, next cycle IVALID=1, ALIGN_ERR=1, Iout=NOP_INSTR.
REQ-037 SHALL cover MEM_LAT=2: PC=8'h20 -> IVALID 7 cycles after REQ, correct bytes captured.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared widths and FSM encoding for the two-byte instruction fetch unit.
package ifetch_pkg;
  localparam int BYTE_W  = 8;
  localparam int INSTR_W = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE_LO = 3'd1,
    WAIT_LO  = 3'd2,
    ISSUE_HI = 3'd3,
    WAIT_HI  = 3'd4,
    DONE     = 3'd5
  } state_t;
endpackage

// File: rtl/instr_fetch.sv
// Fetches a 16-bit instruction as two byte reads (PC, PC+1) from a byte-wide memory.
// Optional odd-PC rejection is enabled by defining IFETCH_ALIGN_CHK_EN.
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter int                 MEM_LAT   = 1,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0000
) (
  input  logic               CLK,
  input  logic               RESET_L,
  input  logic               REQ,
  input  logic [BYTE_W-1:0]  PC,
  output logic [BYTE_W-1:0]  MEM_ADDR,
  output logic               MEM_RD,
  input  logic [BYTE_W-1:0]  MEM_DATA,
  output logic [INSTR_W-1:0] Iout,
  output logic               IVALID,
  output logic               BUSY,
  output logic               ALIGN_ERR
);

  // Wait counter value on the final WAIT_* cycle (MEM_LAT is 1 or 2).
  localparam logic LAST_WAIT = (MEM_LAT == 2);

  state_t               state_q, state_d;
  logic [INSTR_W-1:0]   iout_q, iout_d;
  logic [BYTE_W-1:0]    addr_q, addr_d;
  logic                 wait_q, wait_d;
  logic                 rej_q, rej_d;

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q <= IDLE;
      iout_q  <= '0;
      addr_q  <= '0;
      wait_q  <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      iout_q  <= iout_d;
      addr_q  <= addr_d;
      wait_q  <= wait_d;
      rej_q   <= rej_d;
    end
  end

  always_comb begin
    state_d = state_q;
    iout_d  = iout_q;
    addr_d  = addr_q;
    wait_d  = wait_q;
    rej_d   = rej_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (REQ) begin
`ifdef IFETCH_ALIGN_CHK_EN
          if (PC[0]) begin
            state_d = DONE;
            iout_d  = NOP_INSTR;
            rej_d   = 1'b1;
          end else begin
            state_d = ISSUE_LO;
            addr_d  = PC;
            wait_d  = 1'b0;
            rej_d   = 1'b0;
          end
`else
          state_d = ISSUE_LO;
          addr_d  = PC;
          wait_d  = 1'b0;
          rej_d   = 1'b0;
`endif
        end
      end
      ISSUE_LO: begin
        state_d = WAIT_LO;
        wait_d  = 1'b0;
      end
      WAIT_LO: begin
        if (wait_q == LAST_WAIT) begin
          iout_d[7:0] = MEM_DATA;
          addr_d      = addr_q + 8'd1;
          wait_d      = 1'b0;
          state_d     = ISSUE_HI;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ISSUE_HI: begin
        state_d = WAIT_HI;
        wait_d  = 1'b0;
      end
      WAIT_HI: begin
        if (wait_q == LAST_WAIT) begin
          iout_d[15:8] = MEM_DATA;
          wait_d       = 1'b0;
          state_d      = DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign MEM_ADDR = addr_q;
  assign MEM_RD   = (state_q == ISSUE_LO) || (state_q == ISSUE_HI);
  assign BUSY     = MEM_RD || (state_q == WAIT_LO) || (state_q == WAIT_HI);
  assign IVALID   = (state_q == DONE);
  assign Iout     = iout_q;

`ifdef IFETCH_ALIGN_CHK_EN
  assign ALIGN_ERR = IVALID && rej_q;
`else
  assign ALIGN_ERR = 1'b0;
  logic unused_nop;
  assign unused_nop = ^{NOP_INSTR, rej_q};
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: drives MEM_LAT=1 and MEM_LAT=2 instances with shared stimulus.
module tb_instr_fetch;
  localparam logic [15:0] NOP = 16'hDEAD;

  logic       CLK = 1'b0;
  logic       RESET_L = 1'b0;
  logic       REQ = 1'b0;
  logic [7:0] PC = 8'h00;

  logic [7:0]  addr_a [2];
  logic        rd_a   [2];
  logic [7:0]  data_a [2];
  logic [15:0] iout_a [2];
  logic        iv_a   [2];
  logic        busy_a [2];
  logic        aerr_a [2];

  logic [7:0] mem [256];
  logic [7:0] s1_l1, s1_l2, s2_l2;

  int cyc = 0;
  int nvec = 0;
  int nerr = 0;
  int ivq [2][$];
  logic [7:0] rdq [2][$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  instr_fetch #(.MEM_LAT(1), .NOP_INSTR(NOP)) dut1 (
    .CLK(CLK), .RESET_L(RESET_L), .REQ(REQ), .PC(PC),
    .MEM_ADDR(addr_a[0]), .MEM_RD(rd_a[0]), .MEM_DATA(data_a[0]),
    .Iout(iout_a[0]), .IVALID(iv_a[0]), .BUSY(busy_a[0]), .ALIGN_ERR(aerr_a[0]));

  instr_fetch #(.MEM_LAT(2), .NOP_INSTR(NOP)) dut2 (
    .CLK(CLK), .RESET_L(RESET_L), .REQ(REQ), .PC(PC),
    .MEM_ADDR(addr_a[1]), .MEM_RD(rd_a[1]), .MEM_DATA(data_a[1]),
    .Iout(iout_a[1]), .IVALID(iv_a[1]), .BUSY(busy_a[1]), .ALIGN_ERR(aerr_a[1]));

  // Memories return a poison byte unless read, so mistimed captures show up.
  always @(posedge CLK) begin
    s1_l1 <= rd_a[0] ? mem[addr_a[0]] : 8'hEE;
    s1_l2 <= rd_a[1] ? mem[addr_a[1]] : 8'hEE;
    s2_l2 <= s1_l2;
  end
  assign data_a[0] = s1_l1;
  assign data_a[1] = s2_l2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %0h, want %0h", nm, cyc, act, exp);
    end
  endtask

  // Model: a fetch accepted at cycle t has its reads at t+1 and t+L+2, low byte
  // visible from t+L+2, IVALID at t+2L+3, and is busy for t+1..t+2L+2.
  int          acc_cyc [2] = '{-1000, -1000};
  logic [7:0]  acc_pc  [2];
  bit          acc_rej [2] = '{0, 0};
  logic [15:0] iout_m  [2] = '{16'h0, 16'h0};

  always @(negedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      int L, d;
      bit e_busy, e_rd, e_iv, e_ae;
      logic [7:0] e_addr;
      L = k + 1;
      if (!RESET_L) begin
        acc_cyc[k] = -1000;
        acc_rej[k] = 0;
        iout_m[k]  = 16'h0;
      end
      d = cyc - acc_cyc[k];
      if (acc_rej[k]) begin
        e_busy = 0; e_rd = 0;
        e_iv   = (d == 1);
        e_ae   = (d == 1);
        if (d == 1) iout_m[k] = NOP;
        e_addr = 8'h00;
      end else begin
        e_busy = (d >= 1) && (d <= 2*L + 2);
        e_rd   = (d == 1) || (d == L + 2);
        e_iv   = (d == 2*L + 3);
        e_ae   = 0;
        e_addr = (d == 1) ? acc_pc[k] : 8'(acc_pc[k] + 8'd1);
        if (d == L + 2)   iout_m[k][7:0]  = mem[acc_pc[k]];
        if (d == 2*L + 3) iout_m[k][15:8] = mem[8'(acc_pc[k] + 8'd1)];
      end
      chk($sformatf("busy%0d", k), busy_a[k], e_busy);
      chk($sformatf("mem_rd%0d", k), rd_a[k], e_rd);
      chk($sformatf("ivalid%0d", k), iv_a[k], e_iv);
      chk($sformatf("align_err%0d", k), aerr_a[k], e_ae);
      chk($sformatf("iout%0d", k), iout_a[k], iout_m[k]);
      if (!RESET_L) chk($sformatf("rst_addr%0d", k), addr_a[k], 8'h00);
      else if (e_rd) chk($sformatf("mem_addr%0d", k), addr_a[k], e_addr);
      if (rd_a[k]) rdq[k].push_back(addr_a[k]);
      if (iv_a[k]) ivq[k].push_back(cyc);
      if (RESET_L && REQ && !e_busy) begin
        acc_cyc[k] = cyc;
        acc_pc[k]  = PC;
`ifdef IFETCH_ALIGN_CHK_EN
        acc_rej[k] = PC[0];
`else
        acc_rej[k] = 0;
`endif
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic clrq();
    for (int k = 0; k < 2; k++) begin
      ivq[k].delete();
      rdq[k].delete();
    end
  endtask

  function automatic int q0(input int k, input int idx);
    return (ivq[k].size() > idx) ? ivq[k][idx] : -1;
  endfunction

  initial begin
    int c0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'hA5);
    mem[8'h00] = 8'hCD; mem[8'h02] = 8'h22; mem[8'h03] = 8'h33;
    mem[8'h10] = 8'h34; mem[8'h11] = 8'h12;
    mem[8'h20] = 8'h78; mem[8'h21] = 8'h56;
    mem[8'hFF] = 8'hAB;

    tick(3);
    chk("reset_iout", iout_a[0], 16'h0000);
    RESET_L = 1'b1;
    tick(2);

    // Single fetch at 0x10
    clrq();
    REQ = 1'b1; PC = 8'h10; c0 = cyc;
    tick(1); REQ = 1'b0;
    tick(12);
    chk("single_lat1", q0(0, 0) - c0, 5);
    chk("single_lat2", q0(1, 0) - c0, 7);
    chk("single_iout", iout_a[0], 16'h1234);
    chk("single_nrd", rdq[0].size(), 2);
    if (rdq[0].size() == 2) begin
      chk("single_rd0", rdq[0][0], 8'h10);
      chk("single_rd1", rdq[0][1], 8'h11);
    end

    // Wrap: 0xFE then 0xFF
    REQ = 1'b1; PC = 8'hFE;
    tick(1); REQ = 1'b0;
    tick(10);
    clrq();
    REQ = 1'b1; PC = 8'hFF;
    tick(1); REQ = 1'b0;
    tick(10);
`ifndef IFETCH_ALIGN_CHK_EN
    chk("wrap_nrd", rdq[0].size(), 2);
    if (rdq[0].size() == 2) begin
      chk("wrap_rd0", rdq[0][0], 8'hFF);
      chk("wrap_rd1", rdq[0][1], 8'h00);
    end
    chk("wrap_iout", iout_a[0], 16'hCDAB);
`endif

    // Back-to-back with REQ held; PC changes during BUSY must be ignored
    clrq();
    REQ = 1'b1; PC = 8'h00; c0 = cyc;
    tick(1); PC = 8'h06;
    tick(3); PC = 8'h02;
    tick(4); REQ = 1'b0;
    tick(12);
    chk("b2b_count", ivq[0].size(), 2);
    chk("b2b_first", q0(0, 0) - c0, 5);
    chk("b2b_gap", q0(0, 1) - q0(0, 0), 5);
    chk("b2b_iout", iout_a[0], 16'h3322);

    // Odd PC
    clrq();
    REQ = 1'b1; PC = 8'h05; c0 = cyc;
    tick(1); REQ = 1'b0;
    tick(10);
`ifdef IFETCH_ALIGN_CHK_EN
    chk("align_nrd", rdq[0].size(), 0);
    chk("align_iv", q0(0, 0) - c0, 1);
    chk("align_iout", iout_a[0], NOP);
`else
    chk("odd_iv", q0(0, 0) - c0, 5);
    chk("odd_iout", iout_a[0], {mem[8'h06], mem[8'h05]});
`endif

    // Reset during WAIT_HI of the latency-1 instance, then fetch on the first edge after release
    REQ = 1'b1; PC = 8'h20; c0 = cyc;
    tick(1); REQ = 1'b0;
    tick(3);
    RESET_L = 1'b0;
    #2;
    chk("midrst_busy", busy_a[0], 1'b0);
    chk("midrst_iout", iout_a[0], 16'h0000);
    chk("midrst_iv", iv_a[0], 1'b0);
    tick(2);
    clrq();
    RESET_L = 1'b1; REQ = 1'b1; PC = 8'h20; c0 = cyc;
    tick(1); REQ = 1'b0;
    tick(12);
    chk("postrst_count", ivq[0].size(), 1);
    chk("postrst_lat1", q0(0, 0) - c0, 5);
    chk("lat2_lat", q0(1, 0) - c0, 7);
    chk("lat2_iout", iout_a[1], 16'h5678);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
